reg_bus_arbiter: RTL and testbench
==================================

Name: reg_bus_arbiter

Overview:
- Shares the single register-access bus (wr_en/rd_en/addr/wdata, rdata/ack) between NUM_REQ requesters.
- Typical requesters: the UDP register server, a local control FSM and a debug port.
- Sits between those requesters and the payload-generator register file.
- Captures single-cycle request pulses, grants round-robin, keeps one transaction outstanding, and routes read data and ack back to the requester that issued the read.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 8, register address width
TIMEOUT, 255, read-ack timeout in clk cycles (only with REG_ARB_TIMEOUT_EN)
TIMEOUT_DATA, 32'hDEADBEEF, rdata returned on read timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req_wr_en  in  NUM_REQ  per-requester write pulse
req_rd_en  in  NUM_REQ  per-requester read pulse
req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*32  flattened write data
req_busy  out  NUM_REQ  requester slot occupied (pending or in flight)
req_drop  out  NUM_REQ  1-cycle pulse: request lost because slot was busy
req_ack  out  NUM_REQ  1-cycle read-complete pulse to the issuing requester
req_rdata  out  32  read data, valid when any req_ack bit is high
reg_wr_en  out  1  downstream write strobe
reg_rd_en  out  1  downstream read strobe
reg_addr  out  ADDR_W  downstream address
reg_wdata  out  32  downstream write data
reg_rdata  in  32  downstream read data
reg_ack  in  1  downstream read-data-valid pulse
timeout_err  out  1  1-cycle pulse on read timeout

Behaviour:
- Reset (rst high at a clk edge): all outputs 0; slots empty; state IDLE; round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
- Capture:
  - Each requester has a one-deep slot holding {is_wr, addr, wdata}.
  - A pulse on req_wr_en[i] or req_rd_en[i] with slot i empty loads the slot.
  - If both strobes are high in the same cycle, the write is taken and the read ignored.
  - A pulse while slot i is busy is discarded; req_drop[i] pulses on the next cycle.
  - req_busy[i] = slot valid OR slot i in flight (registered).
- FSM states IDLE, ISSUE, WAIT.
  - IDLE: if any slot is valid, pick the first valid index after the pointer (wrapping modulo NUM_REQ), update the pointer to it, latch grant g, register reg_addr/reg_wdata, and assert reg_wr_en or reg_rd_en for the next cycle. Go to ISSUE.
  - ISSUE: strobe is high for exactly this one cycle.
    - Write: clear slot g, go to IDLE. Writes produce no req_ack.
    - Read: go to WAIT.
  - WAIT: reg_ack is sampled here only.
    - On reg_ack: register req_rdata <= reg_rdata, pulse req_ack[g] next cycle, clear slot g, go to IDLE.
    - reg_ack in IDLE or ISSUE is a stray ack: ignored, no effect.
- Latency:
  - Pulse at cycle N into an idle arbiter: slot valid N+1, strobe high N+2.
  - reg_ack at cycle M: req_ack M+1.
  - Back-to-back writes from different requesters: one strobe every 2 cycles.
- Slot clear and a new capture on the same cycle for the same requester: not possible (busy covers in-flight). A new pulse the cycle after the slot clears is accepted.
- reg_addr/reg_wdata hold their last value between transactions.
- Only the granted requester's ack bit is ever set; at most one req_ack bit is high per cycle.
- Reset mid-transaction: state returns to IDLE, slots are flushed, and no ack is generated for the aborted read.

Optional Feature:
REG_ARB_TIMEOUT_EN
- Defined:
  - A counter starts at 0 on entry to WAIT and increments each cycle.
  - When it reaches TIMEOUT without reg_ack: req_rdata = TIMEOUT_DATA, pulse req_ack[g] and timeout_err on the next cycle, clear slot g, go to IDLE.
  - reg_ack arriving on the same cycle as expiry wins: real data, no timeout_err.
- Undefined: WAIT holds until reg_ack; timeout_err is tied to 0; no counter logic.

Test Plan:
- Write from req0 (addr 0x10, wdata 0x12345678) at cycle N -> reg_wr_en=1, reg_addr=0x10, reg_wdata=0x12345678 at N+2 for exactly 1 cycle; no req_ack.
- Read from req1 (addr 0x04); bench asserts reg_ack with reg_rdata=0xCAFEF00D 3 cycles after reg_rd_en -> req_ack=2'b10 and req_rdata=0xCAFEF00D one cycle later.
- req0 and req1 both pulse writes on the same cycle, twice in a row after completion -> grants ordered 0,1 then 0,1; each strobe 2 cycles apart.
- Second read pulse from req0 while its read is in WAIT -> req_drop[0] pulses; only one downstream reg_rd_en; a single req_ack[0].
- REG_ARB_TIMEOUT_EN, TIMEOUT=8, read with no reg_ack -> req_ack[g] and timeout_err pulse together; req_rdata=0xDEADBEEF; a later stray reg_ack is ignored.
- rst asserted during WAIT, then a stray reg_ack -> all outputs 0; no req_ack; next request is served normally starting with requester 0.

Source files
------------

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one register-access bus between NUM_REQ requesters.
// Each requester owns a one-deep request slot. One downstream transaction is outstanding
// at a time. Read data and ack are routed back to the requester that issued the read.
// Optional read-ack timeout: define REG_ARB_TIMEOUT_EN.
module reg_bus_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned TIMEOUT      = 255,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_wr_en,
  input  logic [NUM_REQ-1:0]        req_rd_en,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]        req_busy,
  output logic [NUM_REQ-1:0]        req_drop,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [31:0]               req_rdata,
  output logic                      reg_wr_en,
  output logic                      reg_rd_en,
  output logic [ADDR_W-1:0]         reg_addr,
  output logic [31:0]               reg_wdata,
  input  logic [31:0]               reg_rdata,
  input  logic                      reg_ack,
  output logic                      timeout_err
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e state_q, state_d;

  logic [NUM_REQ-1:0]             slot_vld_q, slot_wr_q, slot_clr, inflight;
  logic [NUM_REQ-1:0][ADDR_W-1:0] slot_addr_q;
  logic [NUM_REQ-1:0][31:0]       slot_wdata_q;
  logic [NUM_REQ-1:0]             drop_q, ack_q, ack_d;
  logic [IdxW-1:0]                ptr_q, ptr_d, grant_q, grant_d, pick, cand;
  logic                           pick_vld;
  logic                           wr_q, wr_d, rd_q, rd_d, tmo_q, tmo_d;
  logic [ADDR_W-1:0]              addr_q, addr_d;
  logic [31:0]                    wdata_q, wdata_d, rdata_q, rdata_d;

`ifdef REG_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_DATA, 32'(TIMEOUT)};
`endif

  assign req_busy    = slot_vld_q | inflight;
  assign req_drop    = drop_q;
  assign req_ack     = ack_q;
  assign req_rdata   = rdata_q;
  assign reg_wr_en   = wr_q;
  assign reg_rd_en   = rd_q;
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign timeout_err = tmo_q;

  // Slot owned by the transaction currently on the bus.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      inflight[i] = (state_q != StIdle) && (grant_q == IdxW'(i));
    end
  end

  // Request capture into per-requester slots; pulses into a busy slot are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld_q   <= '0;
      slot_wr_q    <= '0;
      slot_addr_q  <= '0;
      slot_wdata_q <= '0;
      drop_q       <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        drop_q[i] <= (req_wr_en[i] | req_rd_en[i]) & req_busy[i];
        if (slot_clr[i]) begin
          slot_vld_q[i] <= 1'b0;
        end else if (!req_busy[i] && (req_wr_en[i] || req_rd_en[i])) begin
          slot_vld_q[i]   <= 1'b1;
          slot_wr_q[i]    <= req_wr_en[i];  // write wins over a simultaneous read
          slot_addr_q[i]  <= req_addr[i*ADDR_W +: ADDR_W];
          slot_wdata_q[i] <= req_wdata[i*32 +: 32];
        end
      end
    end
  end

  // Round-robin pick: first valid slot after the pointer, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdxW'((32'(ptr_q) + k) % NUM_REQ);
      if (!pick_vld && slot_vld_q[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  // Bus FSM next-state and registered outputs.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ack_d    = '0;
    tmo_d    = 1'b0;
    slot_clr = '0;
`ifdef REG_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          ptr_d   = pick;
          grant_d = pick;
          addr_d  = slot_addr_q[pick];
          wdata_d = slot_wdata_q[pick];
          wr_d    = slot_wr_q[pick];
          rd_d    = ~slot_wr_q[pick];
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (slot_wr_q[grant_q]) begin
          slot_clr[grant_q] = 1'b1;
          state_d           = StIdle;
        end else begin
          state_d = StWait;
`ifdef REG_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StWait: begin
        if (reg_ack) begin
          rdata_d           = reg_rdata;
          ack_d[grant_q]    = 1'b1;
          slot_clr[grant_q] = 1'b1;
          state_d           = StIdle;
`ifdef REG_ARB_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT)) begin
          rdata_d           = TIMEOUT_DATA;
          ack_d[grant_q]    = 1'b1;
          tmo_d             = 1'b1;
          slot_clr[grant_q] = 1'b1;
          state_d           = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus FSM state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= IdxW'(NUM_REQ - 1);
      grant_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
      tmo_q   <= 1'b0;
`ifdef REG_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      tmo_q   <= tmo_d;
`ifdef REG_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter (NUM_REQ=2, ADDR_W=8, TIMEOUT=8).
module tb_reg_bus_arbiter;

  localparam int unsigned NumReq = 2;
  localparam int unsigned AddrW  = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NumReq-1:0]        req_wr_en, req_rd_en;
  logic [NumReq*AddrW-1:0]  req_addr;
  logic [NumReq*32-1:0]     req_wdata;
  logic [NumReq-1:0]        req_busy, req_drop, req_ack;
  logic [31:0]              req_rdata;
  logic                     reg_wr_en, reg_rd_en;
  logic [AddrW-1:0]         reg_addr;
  logic [31:0]              reg_wdata, reg_rdata;
  logic                     reg_ack;
  logic                     timeout_err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned rd_strobes = 0;
  int unsigned ack_pulses = 0;
  int unsigned rd0, ack0;

  reg_bus_arbiter #(
    .NUM_REQ(NumReq),
    .ADDR_W (AddrW),
    .TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_wr_en  (req_wr_en),
    .req_rd_en  (req_rd_en),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_busy   (req_busy),
    .req_drop   (req_drop),
    .req_ack    (req_ack),
    .req_rdata  (req_rdata),
    .reg_wr_en  (reg_wr_en),
    .reg_rd_en  (reg_rd_en),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .reg_ack    (reg_ack),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Mid-cycle pulse counters for strobe/ack totals over a window.
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_rd_en) rd_strobes <= rd_strobes + 1;
      if (|req_ack) ack_pulses <= ack_pulses + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input int i, input bit wr, input logic [7:0] a, input logic [31:0] d);
    if (wr) req_wr_en[i] = 1'b1;
    else    req_rd_en[i] = 1'b1;
    req_addr[i*AddrW +: AddrW] = a;
    req_wdata[i*32 +: 32]      = d;
  endtask

  task automatic clear_req();
    req_wr_en = '0;
    req_rd_en = '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 64'(req_busy), 64'h0);
    check({tag, "_drop"}, 64'(req_drop), 64'h0);
    check({tag, "_ack"}, 64'(req_ack), 64'h0);
    check({tag, "_rdata"}, 64'(req_rdata), 64'h0);
    check({tag, "_wr"}, 64'(reg_wr_en), 64'h0);
    check({tag, "_rd"}, 64'(reg_rd_en), 64'h0);
    check({tag, "_addr"}, 64'(reg_addr), 64'h0);
    check({tag, "_wdata"}, 64'(reg_wdata), 64'h0);
    check({tag, "_tmo"}, 64'(timeout_err), 64'h0);
  endtask

  // Two simultaneous writes; expects grants in order (first, second), 2 cycles apart.
  task automatic dual_write(input int first, input logic [7:0] a0, input logic [7:0] a1);
    int second;
    logic [7:0] af, as_;
    second = 1 - first;
    af  = (first == 0) ? a0 : a1;
    as_ = (first == 0) ? a1 : a0;
    post(0, 1'b1, a0, {24'hA0A0A0, a0});
    post(1, 1'b1, a1, {24'hB1B1B1, a1});
    tick();
    clear_req();
    check("dw_busy", 64'(req_busy), 64'h3);
    check("dw_e1_wr", 64'(reg_wr_en), 64'h0);
    tick();
    check("dw_e2_wr", 64'(reg_wr_en), 64'h1);
    check("dw_e2_addr", 64'(reg_addr), 64'(af));
    tick();
    check("dw_e3_wr", 64'(reg_wr_en), 64'h0);
    check("dw_e3_busy", 64'(req_busy), 64'(2'b1 << second));
    tick();
    check("dw_e4_wr", 64'(reg_wr_en), 64'h1);
    check("dw_e4_addr", 64'(reg_addr), 64'(as_));
    tick();
    check("dw_e5_wr", 64'(reg_wr_en), 64'h0);
    check("dw_e5_busy", 64'(req_busy), 64'h0);
    check("dw_e5_ack", 64'(req_ack), 64'h0);
  endtask

  initial begin
    rst       = 1'b1;
    req_wr_en = '0;
    req_rd_en = '0;
    req_addr  = '0;
    req_wdata = '0;
    reg_rdata = '0;
    reg_ack   = 1'b0;
    tick();
    tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Single write from requester 0
    post(0, 1'b1, 8'h10, 32'h12345678);
    tick();
    clear_req();
    check("w_e1_busy", 64'(req_busy), 64'h1);
    check("w_e1_wr", 64'(reg_wr_en), 64'h0);
    tick();
    check("w_e2_wr", 64'(reg_wr_en), 64'h1);
    check("w_e2_rd", 64'(reg_rd_en), 64'h0);
    check("w_e2_addr", 64'(reg_addr), 64'h10);
    check("w_e2_wdata", 64'(reg_wdata), 64'h12345678);
    tick();
    check("w_e3_wr", 64'(reg_wr_en), 64'h0);
    check("w_e3_busy", 64'(req_busy), 64'h0);
    check("w_e3_ack", 64'(req_ack), 64'h0);
    check("w_e3_addr_hold", 64'(reg_addr), 64'h10);

    // Read from requester 1, ack 3 cycles after the strobe
    post(1, 1'b0, 8'h04, 32'h0);
    tick();
    clear_req();
    tick();
    check("r_e2_rd", 64'(reg_rd_en), 64'h1);
    check("r_e2_addr", 64'(reg_addr), 64'h04);
    for (int k = 3; k <= 5; k++) begin
      tick();
      check("r_wait_rd", 64'(reg_rd_en), 64'h0);
      check("r_wait_ack", 64'(req_ack), 64'h0);
      check("r_wait_busy", 64'(req_busy), 64'h2);
    end
    reg_ack   = 1'b1;
    reg_rdata = 32'hCAFEF00D;
    tick();
    reg_ack = 1'b0;
    check("r_ack", 64'(req_ack), 64'h2);
    check("r_rdata", 64'(req_rdata), 64'hCAFEF00D);
    check("r_busy_clr", 64'(req_busy), 64'h0);
    tick();
    check("r_ack_pulse", 64'(req_ack), 64'h0);

    // Simultaneous writes, twice: pointer at 1 so 0 then 1 each round
    dual_write(0, 8'h20, 8'h21);
    dual_write(0, 8'h30, 8'h31);

    // Read from requester 0 with a second pulse during WAIT
    rd0  = rd_strobes;
    ack0 = ack_pulses;
    post(0, 1'b0, 8'h40, 32'h0);
    tick();
    clear_req();
    tick();
    check("d_e2_rd", 64'(reg_rd_en), 64'h1);
    tick();
    post(0, 1'b0, 8'h41, 32'h0);
    tick();
    clear_req();
    check("d_drop", 64'(req_drop), 64'h1);
    tick();
    check("d_drop_pulse", 64'(req_drop), 64'h0);
    reg_ack   = 1'b1;
    reg_rdata = 32'h55AA55AA;
    tick();
    reg_ack = 1'b0;
    check("d_ack", 64'(req_ack), 64'h1);
    check("d_rdata", 64'(req_rdata), 64'h55AA55AA);
    tick();
    tick();
    tick();
    check("d_busy", 64'(req_busy), 64'h0);
    check("d_rd_count", 64'(rd_strobes - rd0), 64'h1);
    check("d_ack_count", 64'(ack_pulses - ack0), 64'h1);

    // Pointer now at 0: simultaneous writes granted 1 then 0
    dual_write(1, 8'h38, 8'h39);

    // Read with no downstream ack
    post(0, 1'b0, 8'h70, 32'h0);
    tick();
    clear_req();
    tick();
    check("t_e2_rd", 64'(reg_rd_en), 64'h1);
`ifdef REG_ARB_TIMEOUT_EN
    for (int k = 3; k <= 11; k++) begin
      tick();
      check("t_wait_ack", 64'(req_ack), 64'h0);
      check("t_wait_tmo", 64'(timeout_err), 64'h0);
    end
    tick();
    check("t_ack", 64'(req_ack), 64'h1);
    check("t_tmo", 64'(timeout_err), 64'h1);
    check("t_rdata", 64'(req_rdata), 64'hDEADBEEF);
    tick();
    check("t_ack_pulse", 64'(req_ack), 64'h0);
    check("t_tmo_pulse", 64'(timeout_err), 64'h0);
    check("t_busy", 64'(req_busy), 64'h0);
`else
    for (int k = 3; k <= 22; k++) begin
      tick();
      check("t_hold_ack", 64'(req_ack), 64'h0);
      check("t_hold_tmo", 64'(timeout_err), 64'h0);
    end
    check("t_hold_busy", 64'(req_busy), 64'h1);
    reg_ack   = 1'b1;
    reg_rdata = 32'h0BADCAFE;
    tick();
    reg_ack = 1'b0;
    check("t_late_ack", 64'(req_ack), 64'h1);
    check("t_late_rdata", 64'(req_rdata), 64'h0BADCAFE);
    tick();
    check("t_late_pulse", 64'(req_ack), 64'h0);
`endif
    // Stray ack while idle is ignored
    reg_ack   = 1'b1;
    reg_rdata = 32'h11111111;
    tick();
    reg_ack = 1'b0;
    tick();
    check("stray_ack", 64'(req_ack), 64'h0);
    check("stray_tmo", 64'(timeout_err), 64'h0);
`ifdef REG_ARB_TIMEOUT_EN
    check("stray_rdata", 64'(req_rdata), 64'hDEADBEEF);
`else
    check("stray_rdata", 64'(req_rdata), 64'h0BADCAFE);
`endif

    // Reset during WAIT, then stray ack, then normal service from requester 0
    post(0, 1'b0, 8'h50, 32'h0);
    tick();
    clear_req();
    tick();
    check("rs_e2_rd", 64'(reg_rd_en), 64'h1);
    tick();
    tick();
    rst       = 1'b1;
    reg_ack   = 1'b1;
    reg_rdata = 32'h99999999;
    tick();
    check_idle_outputs("rs");
    rst = 1'b0;
    tick();
    reg_ack = 1'b0;
    check("rs_stray_ack", 64'(req_ack), 64'h0);
    check("rs_busy", 64'(req_busy), 64'h0);
    tick();
    check("rs_no_ack", 64'(req_ack), 64'h0);
    dual_write(0, 8'h60, 8'h61);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
